prng_arb_wb8: RTL

Two-port round-robin controller that shares the 8-bit Wishbone PRNG peripheral between two 32-bit requesters, such as the CPU-side bus bridge and a DMA/test engine. Each requester issues one whole-word operation: a seed write or a random-word read. The block sequences it into four single-byte Wishbone accesses at addresses 0..3. Byte 3 is always accessed last, so a read returns a consistent snapshot of the generator state, and the generator then advances exactly once per word read.

---
 rtl/prng_arb_wb8.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/prng_arb_wb8.sv
// Round-robin sharing of the 8-bit Wishbone PRNG between two 32-bit requesters.
// Each word operation becomes four single-strobe byte accesses, with address 3 always last.
`timescale 1ns/1ps

module prng_arb_wb8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] seed0_i,
  input  logic [31:0] seed1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] data0_o,
  output logic [31:0] data1_o,
  output logic [1:0]  ADR_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {IDLE, STB, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic        port_q, port_nx;
  logic        we_q, we_nx;
  logic [31:0] seed_q, seed_nx;
  logic [1:0]  idx_q, idx_nx;
  logic [7:0]  cnt_q, cnt_nx;
  logic        err_q, err_nx;
  logic [31:0] word_q, word_nx;
  logic        last_q, last_nx;

  logic        stb_nx, wbwe_nx;
  logic [1:0]  adr_nx;
  logic [7:0]  dat_nx;
  logic        ack0_nx, ack1_nx, err0_nx, err1_nx;
  logic [31:0] data0_nx, data1_nx;
  logic        grant, done_go;
  logic [1:0]  idx_inc;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state   <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      seed_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b1;
      STB_O   <= 1'b0;
      WE_O    <= 1'b0;
      ADR_O   <= '0;
      DAT_O   <= '0;
      ack0_o  <= 1'b0;
      ack1_o  <= 1'b0;
      err0_o  <= 1'b0;
      err1_o  <= 1'b0;
      data0_o <= '0;
      data1_o <= '0;
    end else begin
      state   <= state_nx;
      port_q  <= port_nx;
      we_q    <= we_nx;
      seed_q  <= seed_nx;
      idx_q   <= idx_nx;
      cnt_q   <= cnt_nx;
      err_q   <= err_nx;
      word_q  <= word_nx;
      last_q  <= last_nx;
      STB_O   <= stb_nx;
      WE_O    <= wbwe_nx;
      ADR_O   <= adr_nx;
      DAT_O   <= dat_nx;
      ack0_o  <= ack0_nx;
      ack1_o  <= ack1_nx;
      err0_o  <= err0_nx;
      err1_o  <= err1_nx;
      data0_o <= data0_nx;
      data1_o <= data1_nx;
    end
  end

  // STB_O is only raised on entry to STB, and STB always falls through to WAIT,
  // so the strobe can never stay high across two edges.
  always_comb begin
    state_nx = state;
    port_nx  = port_q;
    we_nx    = we_q;
    seed_nx  = seed_q;
    idx_nx   = idx_q;
    cnt_nx   = cnt_q;
    err_nx   = err_q;
    word_nx  = word_q;
    last_nx  = last_q;
    stb_nx   = 1'b0;
    wbwe_nx  = WE_O;
    adr_nx   = ADR_O;
    dat_nx   = DAT_O;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
    err0_nx  = 1'b0;
    err1_nx  = 1'b0;
    data0_nx = data0_o;
    data1_nx = data1_o;
    grant    = 1'b0;
    done_go  = 1'b0;
    idx_inc  = idx_q + 2'd1;

    unique case (state)
      IDLE: begin
        if (req0_i || req1_i) begin
          grant    = (req0_i && req1_i) ? ~last_q : req1_i;
          port_nx  = grant;
          last_nx  = grant;
          we_nx    = grant ? we1_i : we0_i;
          seed_nx  = grant ? seed1_i : seed0_i;
          idx_nx   = 2'd0;
          err_nx   = 1'b0;
          word_nx  = '0;
          state_nx = STB;
          stb_nx   = 1'b1;
          wbwe_nx  = we_nx;
          adr_nx   = 2'd0;
          dat_nx   = seed_nx[7:0];
        end
      end
      STB: begin
        cnt_nx   = 8'(TIMEOUT);
        state_nx = WAIT;
      end
      WAIT: begin
        if (ACK_I) begin
          if (!we_q) word_nx[{idx_q, 3'b000} +: 8] = DAT_I;
          if (idx_q == 2'd3) begin
            done_go = 1'b1;
          end else begin
            idx_nx   = idx_inc;
            state_nx = STB;
            stb_nx   = 1'b1;
            adr_nx   = idx_inc;
            dat_nx   = seed_q[{idx_inc, 3'b000} +: 8];
          end
        end else if (cnt_q <= 8'd1) begin
          err_nx  = 1'b1;
          done_go = 1'b1;
        end else begin
          cnt_nx = cnt_q - 8'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Completion and abort both land here; a write leaves the port's data alone.
    if (done_go) begin
      state_nx = DONE;
      if (port_q) begin
        ack1_nx = 1'b1;
        err1_nx = err_nx;
        if (!we_q) data1_nx = word_nx;
      end else begin
        ack0_nx = 1'b1;
        err0_nx = err_nx;
        if (!we_q) data0_nx = word_nx;
      end
    end
  end

endmodule
